// File: rtl/fft_output_reorder.sv
// fft_output_reorder: bit-reversal reorder stage for the 64-point FFT.
// Results are written at the bit-reversed address of their index into one
// of two 64-entry banks; completed banks are streamed out in natural bin
// order over a valid/ready handshake while the other bank captures.
module fft_output_reorder #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [5:0]        in_index,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic [5:0]        out_index,
  output logic              out_last,
  output logic              frame_drop
);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_PRIME,
    RD_STREAM
  } rd_state_e;

  function automatic logic [5:0] bitrev(input logic [5:0] k);
    return {k[0], k[1], k[2], k[3], k[4], k[5]};
  endfunction

  // Bank storage: address = {bank, offset}
  logic [2*DATA_W-1:0] mem_q [0:127];
  logic [2*DATA_W-1:0] rdata_q;

  logic [1:0] full_q, full_d;
  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  logic       wr_active_q, wr_active_d;
  logic       drop_active_q, drop_active_d;
  rd_state_e  rd_state_q, rd_state_d;
  logic [5:0] rd_addr_q, rd_addr_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic       frame_drop_q, frame_drop_d;

  logic       wr_en;
  logic [6:0] wr_addr;
  logic       rd_en;
  logic       accept;
  logic       full_set;
  logic       full_clr;

  // Next-state logic for the capture side, bank flags and read sequencer.
  // The full-flag clear is derived from the registered read state before the
  // read FSM runs, so the FSM can test full_d without a combinational loop.
  always_comb begin
    full_d        = full_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_active_d   = wr_active_q;
    drop_active_d = drop_active_q;
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    frame_drop_d  = 1'b0;
    wr_en         = 1'b0;
    wr_addr       = {wr_bank_q, bitrev(in_index)};
    rd_en         = 1'b0;
    full_set      = 1'b0;

    accept   = out_valid_q & out_ready;
    full_clr = (rd_state_q == RD_STREAM) && accept && (rd_addr_q == 6'd63);

    if (in_valid) begin
      if (in_index == 6'd0) begin
        if (full_q[wr_bank_q]) begin
          drop_active_d = 1'b1;
          wr_active_d   = 1'b0;
          frame_drop_d  = 1'b1;
        end else begin
          wr_active_d   = 1'b1;
          drop_active_d = 1'b0;
          wr_en         = 1'b1;
        end
      end else if (wr_active_q) begin
        wr_en = 1'b1;
        if (in_index == 6'd63) begin
          full_set    = 1'b1;
          wr_bank_d   = ~wr_bank_q;
          wr_active_d = 1'b0;
        end
      end else if (drop_active_q) begin
        if (in_index == 6'd63) begin
          drop_active_d = 1'b0;
        end
      end
    end

    if (full_clr) full_d[rd_bank_q] = 1'b0;
    if (full_set) full_d[wr_bank_q] = 1'b1;

    case (rd_state_q)
      RD_IDLE: begin
        if (full_d[rd_bank_q]) begin
          rd_state_d = RD_PRIME;
          rd_addr_d  = 6'd0;
        end
      end
      RD_PRIME: begin
        rd_en       = 1'b1;
        rd_state_d  = RD_STREAM;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
      end
      RD_STREAM: begin
        if (accept) begin
          if (rd_addr_q == 6'd63) begin
            rd_bank_d   = ~rd_bank_q;
            rd_addr_d   = 6'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_state_d  = full_d[~rd_bank_q] ? RD_PRIME : RD_IDLE;
          end else begin
            rd_addr_d  = rd_addr_q + 6'd1;
            rd_en      = 1'b1;
            out_last_d = (rd_addr_q == 6'd62);
          end
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
      end
    endcase
  end

  // Control and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      wr_active_q   <= 1'b0;
      drop_active_q <= 1'b0;
      rd_state_q    <= RD_IDLE;
      rd_addr_q     <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      frame_drop_q  <= 1'b0;
    end else begin
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_active_q   <= wr_active_d;
      drop_active_q <= drop_active_d;
      rd_state_q    <= rd_state_d;
      rd_addr_q     <= rd_addr_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      frame_drop_q  <= frame_drop_d;
    end
  end

  // Bank write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= {in_re, in_im};
    end
  end

  // Synchronous read port; loads only when a new word is to be presented
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem_q[{rd_bank_q, rd_addr_d}];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_re     = rdata_q[2*DATA_W-1:DATA_W];
  assign out_im     = rdata_q[DATA_W-1:0];
  assign out_index  = rd_addr_q;
  assign out_last   = out_last_q;
  assign frame_drop = frame_drop_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench for fft_output_reorder: a frame-level reference model
// queues expected outputs and drop pulses; a monitor checks them.
module tb_fft_output_reorder;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [5:0]   in_index;
  logic [W-1:0] in_re, in_im;
  logic         out_valid, out_ready, out_last, frame_drop;
  logic [W-1:0] out_re, out_im;
  logic [5:0]   out_index;

  always #5 clk = ~clk;

  fft_output_reorder #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_index(in_index),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_index(out_index),
    .out_last(out_last), .frame_drop(frame_drop)
  );

  typedef struct {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [5:0]   idx;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   drop_q[$];

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit           collecting = 0;
  bit           dropping = 0;
  int           outstanding = 0;
  bit           timed = 0;
  int           last_end = -1000;
  logic [W-1:0] buf_re [64];
  logic [W-1:0] buf_im [64];
  int           ready_mode = 1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < 6; i++) if ((k >> i) & 1) r |= 1 << (5 - i);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completed frame: bin n carries the sample whose index is bitrev(n)
  task automatic push_frame();
    int start;
    start = (cyc + 2 > last_end + 2) ? cyc + 2 : last_end + 2;
    for (int n = 0; n < 64; n++) begin
      exp_t e;
      e.re   = buf_re[bitrev(n)];
      e.im   = buf_im[bitrev(n)];
      e.idx  = 6'(n);
      e.last = (n == 63);
      e.cyc  = timed ? start + n : -1;
      exp_q.push_back(e);
    end
    if (timed) last_end = start + 63;
  endtask

  task automatic model_word(input int idx, input logic [W-1:0] re, input logic [W-1:0] im);
    if (idx == 0) begin
      if (outstanding == 2) begin
        dropping   = 1;
        collecting = 0;
        drop_q.push_back(cyc + 1);
      end else begin
        collecting = 1;
        dropping   = 0;
        buf_re[0]  = re;
        buf_im[0]  = im;
      end
    end else if (collecting) begin
      buf_re[idx] = re;
      buf_im[idx] = im;
      if (idx == 63) begin
        collecting = 0;
        outstanding++;
        push_frame();
      end
    end else if (dropping) begin
      if (idx == 63) dropping = 0;
    end
  endtask

  task automatic send(input int idx, input logic [W-1:0] re, input logic [W-1:0] im);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_index = 6'(idx);
    in_re    = re;
    in_im    = im;
    model_word(idx, re, im);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_frame(input int base, input int upto, input int maxgap);
    for (int k = 0; k <= upto; k++) begin
      send(k, W'(base + k), W'(-(base + k)));
      if (maxgap > 0) gap($urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    drop_q.delete();
    collecting = 0;
    dropping = 0;
    outstanding = 0;
    last_end = -1000;
    @(posedge clk); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_drop", frame_drop, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int t = 0;
    while (exp_q.size() > 0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), limit);
    end
    gap(3);
    check("idle_out_valid", out_valid, 0);
  endtask

  // out_ready driver
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: drop pulses, hold stability under backpressure, output scoreboard
  bit                 held = 0;
  logic [2*W+7:0]     prev_vec;
  always @(negedge clk) begin
    logic [2*W+7:0] cur;
    cur = {out_valid, out_re, out_im, out_index, out_last};
    if (rst) begin
      held = 0;
    end else begin
      if (drop_q.size() > 0 && drop_q[0] == cyc) begin
        check("frame_drop_pulse", frame_drop, 1);
        void'(drop_q.pop_front());
      end else begin
        check("frame_drop_quiet", frame_drop, 0);
      end
      if (held) check("hold_stable", cur, prev_vec);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: got bin %0d re %0h with nothing expected (cycle %0d)",
                   out_index, out_re, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_re", out_re, e.re);
          check("out_im", out_im, e.im);
          check("out_index", out_index, e.idx);
          check("out_last", out_last, e.last);
          if (e.cyc >= 0) check("out_cycle", cyc, e.cyc);
          if (e.last) outstanding--;
        end
      end
      held = out_valid && !out_ready;
      prev_vec = cur;
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_index = '0;
    in_re = '0;
    in_im = '0;
    out_ready = 1'b1;
    do_reset();

    // single frame, bin 0 two cycles after the index-63 write
    timed = 1; ready_mode = 1;
    send_frame(0, 63, 0);
    gap(1);
    wait_drain(500);

    // random backpressure
    timed = 0; ready_mode = 2;
    send_frame(16'h200, 63, 0);
    gap(1);
    wait_drain(2000);

    // ping-pong back-to-back with exactly one bubble
    timed = 1; ready_mode = 1;
    gap(2);
    send_frame(0, 63, 0);
    send_frame(100, 63, 0);
    gap(1);
    wait_drain(1000);

    // overflow: third frame dropped
    timed = 0; ready_mode = 0;
    gap(2);
    send_frame(300, 63, 0);
    send_frame(400, 63, 0);
    send_frame(500, 63, 0);
    gap(5);
    ready_mode = 1;
    wait_drain(1000);

    // restart at index 20
    timed = 1; ready_mode = 1;
    send_frame(600, 20, 0);
    send_frame(700, 63, 0);
    gap(1);
    wait_drain(500);

    // reset while streaming, then stray indices and a fresh frame
    timed = 0;
    send_frame(800, 63, 0);
    gap(10);
    do_reset();
    gap(5);
    check("post_rst_valid", out_valid, 0);
    send(5, 16'h1111, 16'h2222);
    send(9, 16'h3333, 16'h4444);
    gap(2);
    send_frame(900, 63, 0);
    gap(1);
    wait_drain(500);

    // randomized traffic: gaps, aborted frames, stray words, random ready
    ready_mode = 2;
    for (int f = 0; f < 8; f++) begin
      int base;
      int upto;
      base = int'($urandom_range(0, 65535));
      upto = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 62)) : 63;
      if ($urandom_range(0, 3) == 0) send(int'($urandom_range(1, 63)), W'($urandom), W'($urandom));
      send_frame(base, upto, int'($urandom_range(0, 2)));
      gap($urandom_range(0, 3));
    end
    gap(1);
    wait_drain(4000);

    check("leftover_expected", exp_q.size(), 0);
    check("leftover_drops", drop_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_output_reorder.md
# fft_output_reorder

Bit-reversal reorder stage directly downstream of the output index counter in the 64-point FFT processor. It captures the 64 results of one transform, tagged with the counter's 6-bit index and valid strobe, into a ping-pong pair of 64-entry banks. Each result is written at the bit-reversed address of its index, and completed frames are streamed out in natural bin order over a valid/ready handshake. Two banks allow the next frame to be captured while the previous one drains.

## Interface
- DATA_W, default 16: width of the real and imaginary parts, two's complement; the block passes them through unchanged.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  result strobe, from the counter's datavalid.
- in_index  in  6  result index 0..63, from counter_o.
- in_re, in_im  in  DATA_W  result data, aligned with in_valid.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_re, out_im  out  DATA_W  output data, natural bin order.
- out_index  out  6  bin number n of the current output word.
- out_last  out  1  high with bin 63.
- frame_drop  out  1  one-cycle pulse when an incoming frame is discarded.

## Operation
- Bank state:
  - full[1:0] flags, wr_bank pointer, rd_bank pointer, wr_active flag, drop_active flag.
  - Reset value of all of these is 0.
- Address mapping: bitrev(k) = {k[0],k[1],k[2],k[3],k[4],k[5]}.
- Write side, when in_valid=1:
  - Frame start is in_valid with in_index=0.
    - If full[wr_bank]=0: set wr_active.
    - If full[wr_bank]=1: set drop_active and pulse frame_drop.
  - While wr_active: write {in_re,in_im} to bank[wr_bank][bitrev(in_index)].
  - Write with in_index=63 while wr_active: set full[wr_bank], toggle wr_bank, clear wr_active.
  - While drop_active: no writes. Index 63 clears drop_active.
  - in_valid with in_index≠0 while both wr_active and drop_active are 0: ignored, no writes.
  - Index 0 arriving while wr_active (restart): rewrite the same bank from the start; no drop pulse.
- Read side:
  - States are IDLE, PRIME and STREAM.
  - IDLE → PRIME when full[rd_bank]=1. Read address is set to 0.
  - PRIME: synchronous RAM read of address 0, then → STREAM.
  - STREAM:
    - out_valid=1 and out_index=rd_addr.
    - Data = bank[rd_bank][rd_addr].
    - Accept = out_valid & out_ready.
    - On accept: address +1 and the next word is presented the following cycle, giving full throughput with out_ready held high.
    - With out_ready low: out_valid and all output fields hold steady.
  - Accept of bin 63:
    - Clear full[rd_bank] and toggle rd_bank.
    - Go to PRIME if the other bank is already full, otherwise IDLE. The next frame is never skipped.
- Simultaneous events:
  - A read-side clear and a write-side set of full on the same edge are always on different banks, so both take effect.
  - A bank freed by accept at edge T can be selected for a frame starting at index 0 in cycle T+1.
- Reset mid-operation:
  - Frames are abandoned and bank contents are don't-care.
  - Outputs return to their reset values on the next edge.

## Timing
- Reset values: out_valid=0, out_last=0, frame_drop=0, out_index=0, out_re=0, out_im=0.
- Index-63 write in cycle T:
  - full set at T+1.
  - PRIME in T+1.
  - out_valid=1 with bin 0 in T+2, provided the reader was IDLE.
- Output cadence: with out_ready=1 continuously, bins 0..63 appear on 64 consecutive cycles T+2..T+65.
- Back-to-back frames, second bank full when bin 63 is accepted at edge E:
  - PRIME in cycle E+1.
  - Bin 0 of the next frame in E+2, so there is 1 bubble cycle.
- frame_drop is exactly 1 cycle, in the cycle after the dropped frame's index-0 strobe.
- Input side has no backpressure: in_valid is accepted every cycle.

## Test plan
- Reset check:
  - Stimulus: assert rst for 2 cycles mid-stream.
  - Required: all outputs 0 the following cycle, and no out_valid until a complete new frame arrives.
- Single frame:
  - Stimulus: index k carries re=k, im=-k for k=0..63, out_ready=1.
  - Required: output n has re=bitrev(n) (n=1→32, n=2→16, n=63→63), out_last only at n=63, bin 0 appears at T+2.
- Backpressure:
  - Stimulus: toggle out_ready at random.
  - Required: no output field changes while out_valid=1 and out_ready=0; exactly 64 accepts, in order.
- Ping-pong:
  - Stimulus: two consecutive frames with re=k and re=100+k, out_ready=1.
  - Required: 128 outputs, second frame values 100+bitrev(n), exactly one bubble between the frames.
- Overflow:
  - Stimulus: out_ready=0 and three frames sent.
  - Required: frame_drop pulses once, at the third frame's start. After releasing out_ready, frames 1 and 2 are output intact and frame 3 never appears.
- Restart:
  - Stimulus: frame aborted at index 20, then a new full frame starting at index 0.
  - Required: only the new frame's data is output, and frame_drop never pulses.
